// File: rtl/bin_maxpool2x2_pkg.sv
// ============================================================================
// Module   : bin_maxpool2x2_pkg
// Brief    : Shared constants, header field layout and the one-hot state
//            encoding used by the binary 2x2 max-pool stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bin_maxpool2x2_pkg;

    // End-of-list marker, both in the input list and the output list
    localparam logic [15:0] C_TERMINATOR = 16'h00FF;

    // Header word: map dimension lives in the low five bits
    localparam int C_HDR_LSB = 0;
    localparam int C_HDR_MSB = 4;
    localparam int C_DIM_W   = C_HDR_MSB - C_HDR_LSB + 1;

    // Dimensions the upstream conv engine can produce
    localparam logic [C_DIM_W-1:0] C_DIM_8  = 5'd8;
    localparam logic [C_DIM_W-1:0] C_DIM_10 = 5'd10;
    localparam logic [C_DIM_W-1:0] C_DIM_14 = 5'd14;

    // One-hot states, matching the other compute stages
    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_HDR  = 5'b00010,
        S_ROWA = 5'b00100,
        S_ROWB = 5'b01000,
        S_TERM = 5'b10000
    } state_t;

    // True for the dimensions this stage knows how to pool
    function automatic logic dim_is_legal(input logic [C_DIM_W-1:0] dim);
        return (dim == C_DIM_8) || (dim == C_DIM_10) || (dim == C_DIM_14);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin_maxpool2x2_if.sv
// ============================================================================
// Module   : bin_maxpool2x2_if
// Brief    : Run/busy handshake plus single-port SRAM read and write buses
//            of the max-pool stage. slave = the pool stage, master = the
//            controller/SRAM side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bin_maxpool2x2_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);

    logic              dut_run;
    logic              dut_busy;
    logic [ADDR_W-1:0] dut_sram_read_address;
    logic [DATA_W-1:0] sram_dut_read_data;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic              dut_sram_write_enable;

    modport slave (
        input  dut_run,
        input  sram_dut_read_data,
        output dut_busy,
        output dut_sram_read_address,
        output dut_sram_write_address,
        output dut_sram_write_data,
        output dut_sram_write_enable
    );

    modport master (
        output dut_run,
        output sram_dut_read_data,
        input  dut_busy,
        input  dut_sram_read_address,
        input  dut_sram_write_address,
        input  dut_sram_write_data,
        input  dut_sram_write_enable
    );

endinterface

`default_nettype wire

// File: rtl/bin_or_pool_row.sv
// ============================================================================
// Module   : bin_or_pool_row
// Brief    : Combinational 2x2 stride-2 OR pool of two binary rows. Output
//            bit j is the OR of columns 2j and 2j+1 of both rows, kept only
//            for j < dim/2; all higher output bits are zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_or_pool_row
    import bin_maxpool2x2_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0]  i_row_a,
    input  logic [DATA_W-1:0]  i_row_b,
    input  logic [C_DIM_W-1:0] i_dim,
    output logic [DATA_W-1:0]  o_pooled
);

    localparam int C_OUT_BITS = DATA_W / 2;

    logic [C_DIM_W-1:0] w_half;

    // Dims are even, so column pair j lies inside the map exactly when j < dim/2
    assign w_half = i_dim >> 1;

    genvar j;
    generate
        for (j = 0; j < C_OUT_BITS; j++) begin : g_pool
            logic w_any;
            assign w_any       = i_row_a[2*j] | i_row_a[2*j+1] | i_row_b[2*j] | i_row_b[2*j+1];
            assign o_pooled[j] = w_any & (C_DIM_W'(j) < w_half);
        end
        for (j = C_OUT_BITS; j < DATA_W; j++) begin : g_zero
            assign o_pooled[j] = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/bin_maxpool2x2.sv
// ============================================================================
// Module   : bin_maxpool2x2
// Brief    : Reads a list of binary feature-map frames from the conv output
//            SRAM, OR-pools each 2x2 block with stride 2 and writes a list of
//            pooled frames (header D/2 + D/2 rows) ended by 16'h00FF.
//            Reads are back-to-back: one input row is consumed per cycle,
//            one pooled word is written every second cycle.
//            Optional: define BIN_MAXPOOL_FRAME_CNT_EN to add an 8-bit
//            saturating frame_count output of frames pooled in the job.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_maxpool2x2
    import bin_maxpool2x2_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int MAX_DIM = 14
) (
    input  logic clk,
    input  logic reset,
`ifdef BIN_MAXPOOL_FRAME_CNT_EN
    output logic [7:0] frame_count,
`endif
    bin_maxpool2x2_if.slave bus
);

    localparam int C_HALF_W = C_DIM_W - 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wr_en;
    logic [DATA_W-1:0]   r_row_a;
    logic [C_DIM_W-1:0]  r_dim;
    logic [C_HALF_W-1:0] r_half;
    logic [C_HALF_W-1:0] r_pair_cnt;

    logic [C_DIM_W-1:0]  w_hdr_dim;
    logic                w_hdr_legal;
    logic                w_last_pair;
    logic [DATA_W-1:0]   w_pooled;

    assign w_hdr_dim   = bus.sram_dut_read_data[C_HDR_MSB:C_HDR_LSB];
    // An illegal dimension ends the list just like the terminator word does
    assign w_hdr_legal = dim_is_legal(w_hdr_dim)
                      && (int'(w_hdr_dim) <= MAX_DIM)
                      && (bus.sram_dut_read_data != DATA_W'(C_TERMINATOR));
    assign w_last_pair = (r_pair_cnt == (r_half - C_HALF_W'(1)));

    // Row B is taken straight off the read bus in ROWB, row A from the latch
    bin_or_pool_row #(
        .DATA_W (DATA_W)
    ) u_pool (
        .i_row_a  (r_row_a),
        .i_row_b  (bus.sram_dut_read_data),
        .i_dim    (r_dim),
        .o_pooled (w_pooled)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.dut_run) w_state_nxt = S_HDR;
            S_HDR:   w_state_nxt = w_hdr_legal ? S_ROWA : S_TERM;
            S_ROWA:  w_state_nxt = S_ROWB;
            S_ROWB:  w_state_nxt = w_last_pair ? S_HDR : S_ROWA;
            S_TERM:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pointers, row latch, frame bookkeeping and the registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_row_a    <= '0;
            r_dim      <= '0;
            r_half     <= '0;
            r_pair_cnt <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Address 0 is already on the bus; step past it so the
                    // row after the header is requested while HDR decodes
                    if (bus.dut_run) begin
                        r_busy   <= 1'b1;
                        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                    end
                end
                S_HDR: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_wr_ptr;
                    r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
                    if (w_hdr_legal) begin
                        r_wr_data  <= DATA_W'(w_hdr_dim[C_DIM_W-1:1]);
                        r_dim      <= w_hdr_dim;
                        r_half     <= w_hdr_dim[C_DIM_W-1:1];
                        r_pair_cnt <= '0;
                        r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                    end else begin
                        // Stop reading; the terminator goes out during TERM
                        r_wr_data <= DATA_W'(C_TERMINATOR);
                    end
                end
                S_ROWA: begin
                    r_row_a  <= bus.sram_dut_read_data;
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                end
                S_ROWB: begin
                    r_wr_en    <= 1'b1;
                    r_wr_addr  <= r_wr_ptr;
                    r_wr_data  <= w_pooled;
                    r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
                    r_pair_cnt <= r_pair_cnt + C_HALF_W'(1);
                    r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                end
                S_TERM: begin
                    r_busy   <= 1'b0;
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef BIN_MAXPOOL_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    // Frames pooled in the current job, saturating, held after the job ends
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if ((r_state == S_IDLE) && bus.dut_run) begin
            r_frame_cnt <= '0;
        end else if ((r_state == S_ROWB) && w_last_pair && (r_frame_cnt != 8'hFF)) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_count = r_frame_cnt;
`endif

    assign bus.dut_busy               = r_busy;
    assign bus.dut_sram_read_address  = r_rd_ptr;
    assign bus.dut_sram_write_address = r_wr_addr;
    assign bus.dut_sram_write_data    = r_wr_data;
    assign bus.dut_sram_write_enable  = r_wr_en;

endmodule

`default_nettype wire

// File: tb/tb_bin_maxpool2x2.sv
// ============================================================================
// Module   : tb_bin_maxpool2x2
// Brief    : Self-checking bench for bin_maxpool2x2. A table of job images
//            with hand-computed pooled lists is run through SRAM models;
//            hand-written sequences cover run held high and reset in ROWB.
//            With BIN_MAXPOOL_FRAME_CNT_EN defined, frame_count is checked.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_maxpool2x2;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bin_maxpool2x2_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef BIN_MAXPOOL_FRAME_CNT_EN
    logic [7:0] frame_count;
`endif

    bin_maxpool2x2 #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_DIM (14)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
`ifdef BIN_MAXPOOL_FRAME_CNT_EN
        .frame_count (frame_count),
`endif
        .bus         (bus)
    );

    // SRAM models
    logic [15:0] conv_mem [0:63];
    logic [15:0] out_mem  [0:63];
    int          out_tag  [0:63];
    int          wr_count = 0;
    int          job_id   = 0;

    always @(posedge clk) begin
        bus.sram_dut_read_data <= conv_mem[bus.dut_sram_read_address[5:0]];
    end

    always @(posedge clk) begin
        if (bus.dut_sram_write_enable) begin
            out_mem[bus.dut_sram_write_address[5:0]] <= bus.dut_sram_write_data;
            out_tag[bus.dut_sram_write_address[5:0]] <= job_id;
            wr_count <= wr_count + 1;
        end
    end

    typedef struct {
        int               n_in;
        logic [63:0][15:0] img;
        int               n_out;
        logic [31:0][15:0] exp_w;
        int               busy;
        int               max_rd;
    } vec_t;

    vec_t vecs [6];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_in(input int v, input logic [15:0] w);
        vecs[v].img[vecs[v].n_in] = w;
        vecs[v].n_in = vecs[v].n_in + 1;
    endtask

    task automatic add_ins(input int v, input int n, input logic [15:0] w);
        for (int i = 0; i < n; i++) add_in(v, w);
    endtask

    task automatic add_out(input int v, input logic [15:0] w);
        vecs[v].exp_w[vecs[v].n_out] = w;
        vecs[v].n_out = vecs[v].n_out + 1;
    endtask

    task automatic add_outs(input int v, input int n, input logic [15:0] w);
        for (int i = 0; i < n; i++) add_out(v, w);
    endtask

    task automatic load_img(input int v);
        for (int i = 0; i < 64; i++) begin
            conv_mem[i] = (i < vecs[v].n_in) ? vecs[v].img[i] : 16'h0000;
        end
    endtask

    // Run one job from the table, hold run high for 'hold' cycles
    task automatic run_job(input int v, input int hold);
        int wr_base;
        int busy_cyc;
        int max_rd;
        bit done;
        job_id++;
        load_img(v);
        wr_base  = wr_count;
        busy_cyc = 0;
        max_rd   = 0;
        done     = 1'b0;
        @(negedge clk);
        bus.dut_run = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c == hold - 1) bus.dut_run = 1'b0;
            if (bus.dut_busy) begin
                busy_cyc++;
                if (int'(bus.dut_sram_read_address) > max_rd) max_rd = int'(bus.dut_sram_read_address);
            end else if (busy_cyc > 0) begin
                done = 1'b1;
                break;
            end
        end
        bus.dut_run = 1'b0;
        check($sformatf("v%0d job done in time", v), 32'(done), 32'd1);
        check($sformatf("v%0d busy cycles", v), busy_cyc, vecs[v].busy);
        check($sformatf("v%0d max read addr", v), max_rd, vecs[v].max_rd);
        check($sformatf("v%0d idle read addr", v), 32'(bus.dut_sram_read_address), 32'd0);
        check($sformatf("v%0d idle write en", v), 32'(bus.dut_sram_write_enable), 32'd0);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d busy stays low", v), 32'(bus.dut_busy), 32'd0);
        check($sformatf("v%0d write count", v), wr_count - wr_base, vecs[v].n_out);
        for (int i = 0; i < vecs[v].n_out; i++) begin
            check($sformatf("v%0d out word %0d", v, i),
                  (out_tag[i] == job_id) ? 32'(out_mem[i]) : 32'hBAD0_0000,
                  32'(vecs[v].exp_w[i]));
        end
    endtask

    initial begin
        int snap;

        for (int i = 0; i < 6; i++) begin
            vecs[i].n_in  = 0;
            vecs[i].n_out = 0;
            vecs[i].img   = '0;
            vecs[i].exp_w = '0;
        end

        // v0: single dim-8 frame, rows alternate 0001/0000
        add_in(0, 16'd8);
        for (int i = 0; i < 4; i++) begin add_in(0, 16'h0001); add_in(0, 16'h0000); end
        add_in(0, 16'h00FF);
        add_out(0, 16'd4); add_outs(0, 4, 16'h0001); add_out(0, 16'h00FF);
        vecs[0].busy = 11; vecs[0].max_rd = 10;

        // v1: three frames 8/10/14, all rows FFFF
        add_in(1, 16'd8);  add_ins(1, 8, 16'hFFFF);
        add_in(1, 16'd10); add_ins(1, 10, 16'hFFFF);
        add_in(1, 16'd14); add_ins(1, 14, 16'hFFFF);
        add_in(1, 16'h00FF);
        add_out(1, 16'd4); add_outs(1, 4, 16'h000F);
        add_out(1, 16'd5); add_outs(1, 5, 16'h001F);
        add_out(1, 16'd7); add_outs(1, 7, 16'h007F);
        add_out(1, 16'h00FF);
        vecs[1].busy = 37; vecs[1].max_rd = 36;

        // v2: dim 10, only columns >= D set
        add_in(2, 16'd10); add_ins(2, 10, 16'hFC00); add_in(2, 16'h00FF);
        add_out(2, 16'd5); add_outs(2, 5, 16'h0000); add_out(2, 16'h00FF);
        vecs[2].busy = 13; vecs[2].max_rd = 12;

        // v3: terminator at address 0
        add_in(3, 16'h00FF);
        add_out(3, 16'h00FF);
        vecs[3].busy = 2; vecs[3].max_rd = 1;

        // v4: one dim-8 frame with mixed pairs, then illegal dim 12 and junk
        add_in(4, 16'd8);
        add_in(4, 16'h0003); add_in(4, 16'h0000);
        add_in(4, 16'h0040); add_in(4, 16'h0080);
        add_in(4, 16'h0100); add_in(4, 16'h0000);
        add_in(4, 16'h0012); add_in(4, 16'h0020);
        add_in(4, 16'd12); add_in(4, 16'hFFFF); add_in(4, 16'hFFFF);
        add_out(4, 16'd4);
        add_out(4, 16'h0001); add_out(4, 16'h0008); add_out(4, 16'h0000); add_out(4, 16'h0005);
        add_out(4, 16'h00FF);
        vecs[4].busy = 11; vecs[4].max_rd = 10;

        // v5: dim 10 mixed pattern, column 9 and masked columns 10/11
        add_in(5, 16'd10);
        add_in(5, 16'h0155); add_in(5, 16'h0000);
        add_in(5, 16'h0200); add_in(5, 16'h0000);
        add_in(5, 16'h0000); add_in(5, 16'h0001);
        add_in(5, 16'h0300); add_in(5, 16'h0C00);
        add_in(5, 16'h0000); add_in(5, 16'h0000);
        add_in(5, 16'h00FF);
        add_out(5, 16'd5);
        add_out(5, 16'h001F); add_out(5, 16'h0010); add_out(5, 16'h0001);
        add_out(5, 16'h0010); add_out(5, 16'h0000);
        add_out(5, 16'h00FF);
        vecs[5].busy = 13; vecs[5].max_rd = 12;

        // Reset state
        reset       = 1'b1;
        bus.dut_run = 1'b0;
        load_img(3);
        repeat (3) @(negedge clk);
        check("reset busy",       32'(bus.dut_busy), 32'd0);
        check("reset read addr",  32'(bus.dut_sram_read_address), 32'd0);
        check("reset write addr", 32'(bus.dut_sram_write_address), 32'd0);
        check("reset write data", 32'(bus.dut_sram_write_data), 32'd0);
        check("reset write en",   32'(bus.dut_sram_write_enable), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven jobs
        for (int v = 0; v < 6; v++) run_job(v, 1);

        // run held high for several cycles starts a single job
        run_job(0, 4);

`ifdef BIN_MAXPOOL_FRAME_CNT_EN
        run_job(1, 1);
        check("frame_count after three frames", 32'(frame_count), 32'd3);
`endif

        // Reset while in ROWB of the first frame, then a fresh job
        job_id++;
        load_img(1);
        @(negedge clk);
        bus.dut_run = 1'b1;
        @(negedge clk);            // HDR
        bus.dut_run = 1'b0;
        @(negedge clk);            // ROWA
        @(negedge clk);            // ROWB
        snap  = wr_count;
        reset = 1'b1;
        @(negedge clk);
        check("midreset busy",       32'(bus.dut_busy), 32'd0);
        check("midreset write en",   32'(bus.dut_sram_write_enable), 32'd0);
        check("midreset read addr",  32'(bus.dut_sram_read_address), 32'd0);
        check("midreset write addr", 32'(bus.dut_sram_write_address), 32'd0);
        check("midreset write data", 32'(bus.dut_sram_write_data), 32'd0);
        @(negedge clk);
        check("midreset no write", wr_count - snap, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_job(2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
